// File: rtl/prom_nibble_loader_if.sv
// Download and read-port bundle for prom_nibble_loader.
// The loader is the slave: it consumes the download stream and the read
// request, and returns the registered read data.
interface prom_nibble_loader_if #(
  parameter int AW = 8,
  parameter int DW = 4
);
  logic          dn_download;
  logic          dn_wr;
  logic [24:0]   dn_addr;
  logic [7:0]    dn_data;
  logic [AW-1:0] rd_addr;
  logic          rd_cs;
  logic [DW-1:0] rd_data;

  modport master (
    output dn_download, dn_wr, dn_addr, dn_data, rd_addr, rd_cs,
    input  rd_data
  );

  modport slave (
    input  dn_download, dn_wr, dn_addr, dn_data, rd_addr, rd_cs,
    output rd_data
  );
endinterface

// File: rtl/prom_nibble_loader.sv
// prom_nibble_loader: captures a 2**AW x DW PROM image from the download
// stream (one byte per nibble) and serves it with one-cycle read latency.
// Reads return 0 while a load is running or no valid image is present.
// Optional feature macro PROM_CHECKSUM_EN adds an image checksum check
// (parameter EXP_SUM, output sum_ok) that also gates 'loaded'.
module prom_nibble_loader #(
  parameter int          AW        = 8,
  parameter logic [24:0] BASE_ADDR = 25'h0,
  parameter int          DW        = 4
`ifdef PROM_CHECKSUM_EN
  ,
  parameter logic [AW+DW-1:0] EXP_SUM = '0
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  prom_nibble_loader_if.slave   bus,
  output logic                  busy,
  output logic                  loaded,
  output logic                  load_err
`ifdef PROM_CHECKSUM_EN
  ,
  output logic                  sum_ok
`endif
);

  localparam logic [AW:0]  FULL = (AW+1)'(2**AW);
  localparam logic [25:0]  WIN  = 26'(2**AW);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t        state_q, state_d;
  logic          dn_prev_q;
  logic          start_pend_q;
  logic [AW:0]   count_q;
  logic [25:0]   offset;
  logic          in_window;
  logic          wr_en;
  logic [DW-1:0] nibble;
  logic          rise, fall, start;
  logic          image_ok;
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] ram_rd_q;
  logic          blank_q;
  logic          unused_ok;
`ifdef PROM_CHECKSUM_EN
  logic [AW+DW-1:0] sum_q;
`endif

  assign unused_ok = &{1'b0, bus.dn_data[7:DW]};

  assign rise      = bus.dn_download & ~dn_prev_q;
  assign fall      = ~bus.dn_download & dn_prev_q;
  assign start     = rise | start_pend_q;
  assign offset    = {1'b0, bus.dn_addr} - {1'b0, BASE_ADDR};
  assign in_window = (bus.dn_addr >= BASE_ADDR) && (offset < WIN);
  assign wr_en     = (state_q == LOAD) && bus.dn_wr && in_window;
  assign nibble    = bus.dn_data[DW-1:0];
  assign busy      = (state_q == LOAD);

`ifdef PROM_CHECKSUM_EN
  assign image_ok = (count_q == FULL) && (sum_q == EXP_SUM);
`else
  assign image_ok = (count_q == FULL);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: start a session on a download rising edge, close it on the falling edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (fall)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Edge detect, write counting and end-of-session verdict; reset samples dn_download so a held-high line does not start a session.
  always_ff @(posedge clk) begin
    dn_prev_q <= bus.dn_download;
    if (reset) begin
      start_pend_q <= 1'b0;
      count_q      <= '0;
      loaded       <= 1'b0;
      load_err     <= 1'b0;
`ifdef PROM_CHECKSUM_EN
      sum_q        <= '0;
      sum_ok       <= 1'b0;
`endif
    end else begin
      start_pend_q <= (state_q == DONE) && rise;
      case (state_q)
        IDLE: begin
          if (start) begin
            count_q  <= '0;
            loaded   <= 1'b0;
            load_err <= 1'b0;
`ifdef PROM_CHECKSUM_EN
            sum_q    <= '0;
`endif
          end
        end
        LOAD: begin
          if (wr_en) begin
            if (count_q != FULL) count_q <= count_q + 1'b1;
`ifdef PROM_CHECKSUM_EN
            sum_q <= sum_q + (AW+DW)'(nibble);
`endif
          end
        end
        DONE: begin
          loaded   <= image_ok;
          load_err <= ~image_ok;
`ifdef PROM_CHECKSUM_EN
          sum_ok   <= image_ok;
`endif
        end
        default: ;
      endcase
    end
  end

  // Image RAM: one synchronous write port, one synchronous read port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[offset[AW-1:0]] <= nibble;
    if (bus.rd_cs) ram_rd_q <= mem[bus.rd_addr];
  end

  // Blanking flag captured alongside each read so the sequencer sees an empty PROM until a valid image exists.
  always_ff @(posedge clk) begin
    if (reset)          blank_q <= 1'b1;
    else if (bus.rd_cs) blank_q <= busy | ~loaded;
  end

  assign bus.rd_data = blank_q ? '0 : ram_rd_q;

endmodule

// File: tb/tb_prom_nibble_loader.sv
// Directed testbench for prom_nibble_loader.
module tb_prom_nibble_loader;

  localparam int          AW   = 8;
  localparam int          DW   = 4;
  localparam logic [24:0] BASE = 25'h100;

  logic clk = 1'b0;
  logic reset;
  logic busy, loaded, load_err;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  prom_nibble_loader_if #(.AW(AW), .DW(DW)) bus ();

`ifdef PROM_CHECKSUM_EN
  logic sum_ok_main;
  logic busy_ck, loaded_ck, load_err_ck, sum_ok_ck;

  prom_nibble_loader_if #(.AW(AW), .DW(DW)) bus_ck ();
  assign bus_ck.dn_download = bus.dn_download;
  assign bus_ck.dn_wr       = bus.dn_wr;
  assign bus_ck.dn_addr     = bus.dn_addr;
  assign bus_ck.dn_data     = bus.dn_data;
  assign bus_ck.rd_addr     = bus.rd_addr;
  assign bus_ck.rd_cs       = bus.rd_cs;

  prom_nibble_loader #(.AW(AW), .BASE_ADDR(BASE), .DW(DW), .EXP_SUM(12'd1920)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .busy(busy), .loaded(loaded), .load_err(load_err), .sum_ok(sum_ok_main)
  );

  prom_nibble_loader #(.AW(AW), .BASE_ADDR(BASE), .DW(DW), .EXP_SUM(12'd256)) dut_ck (
    .clk(clk), .reset(reset), .bus(bus_ck.slave),
    .busy(busy_ck), .loaded(loaded_ck), .load_err(load_err_ck), .sum_ok(sum_ok_ck)
  );
`else
  prom_nibble_loader #(.AW(AW), .BASE_ADDR(BASE), .DW(DW)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .busy(busy), .loaded(loaded), .load_err(load_err)
  );
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dn_write(input logic [24:0] a, input logic [7:0] d);
    bus.dn_wr   = 1'b1;
    bus.dn_addr = a;
    bus.dn_data = d;
    tick();
    bus.dn_wr   = 1'b0;
  endtask

  task automatic session_begin();
    bus.dn_download = 1'b1;
    tick();
  endtask

  task automatic session_end();
    bus.dn_download = 1'b0;
    tick();
    tick();
  endtask

  task automatic load_pattern(input logic [7:0] key);
    session_begin();
    for (int i = 0; i < 256; i++) dn_write(BASE + 25'(i), 8'(i) ^ key);
    session_end();
  endtask

  task automatic read_at(input logic [7:0] a);
    bus.rd_addr = a;
    bus.rd_cs   = 1'b1;
    tick();
    bus.rd_cs   = 1'b0;
  endtask

  task automatic test_reset();
    bus.dn_download = 1'b0;
    bus.dn_wr       = 1'b0;
    bus.dn_addr     = '0;
    bus.dn_data     = '0;
    bus.rd_addr     = '0;
    bus.rd_cs       = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++; if (bus.rd_data !== 4'h0) begin errors++; $display("[TB] FAIL reset_rd_data got %h expected 0", bus.rd_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
    checks++; if (loaded !== 1'b0) begin errors++; $display("[TB] FAIL reset_loaded got %b expected 0", loaded); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_load_err got %b expected 0", load_err); end
  endtask

  task automatic test_full_load();
    logic [7:0] v;
    session_begin();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL full_busy got %b expected 1", busy); end
    for (int i = 0; i < 256; i++) dn_write(BASE + 25'(i), 8'(i) ^ 8'hA5);
    session_end();
    checks++; if (loaded !== 1'b1) begin errors++; $display("[TB] FAIL full_loaded got %b expected 1", loaded); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL full_load_err got %b expected 0", load_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL full_busy_after got %b expected 0", busy); end
`ifdef PROM_CHECKSUM_EN
    checks++; if (sum_ok_main !== 1'b1) begin errors++; $display("[TB] FAIL full_sum_ok got %b expected 1", sum_ok_main); end
`endif
    for (int i = 0; i < 256; i++) begin
      read_at(8'(i));
      v = 8'(i) ^ 8'hA5;
      checks++;
      if (bus.rd_data !== v[3:0]) begin errors++; $display("[TB] FAIL full_read addr %0h got %h expected %h", i, bus.rd_data, v[3:0]); end
    end
  endtask

  task automatic test_short_load();
    logic [7:0] addrs [5];
    addrs = '{8'h00, 8'h01, 8'h64, 8'hC7, 8'hFF};
    session_begin();
    for (int i = 0; i < 200; i++) dn_write(BASE + 25'(i), 8'(i) ^ 8'h3C);
    session_end();
    checks++; if (load_err !== 1'b1) begin errors++; $display("[TB] FAIL short_load_err got %b expected 1", load_err); end
    checks++; if (loaded !== 1'b0) begin errors++; $display("[TB] FAIL short_loaded got %b expected 0", loaded); end
    for (int k = 0; k < 5; k++) begin
      read_at(addrs[k]);
      checks++;
      if (bus.rd_data !== 4'h0) begin errors++; $display("[TB] FAIL short_read addr %0h got %h expected 0", addrs[k], bus.rd_data); end
    end
  endtask

  task automatic test_window_filter();
    // 255 in-window writes plus two outside the window must not complete an image
    session_begin();
    dn_write(BASE - 25'd1, 8'hFF);
    for (int i = 0; i < 255; i++) dn_write(BASE + 25'(i), 8'(i) ^ 8'h5A);
    dn_write(BASE + 25'd256, 8'hFF);
    session_end();
    checks++; if (load_err !== 1'b1) begin errors++; $display("[TB] FAIL window_short_err got %b expected 1", load_err); end
    checks++; if (loaded !== 1'b0) begin errors++; $display("[TB] FAIL window_short_loaded got %b expected 0", loaded); end
    // full image with stray writes before, during and after
    session_begin();
    dn_write(BASE - 25'd1, 8'hFF);
    for (int i = 0; i < 256; i++) begin
      dn_write(BASE + 25'(i), 8'(i) ^ 8'h5A);
      if (i == 127) dn_write(BASE + 25'd256, 8'hFF);
    end
    dn_write(BASE - 25'd1, 8'hFF);
    dn_write(BASE + 25'd256, 8'hFF);
    session_end();
    checks++; if (loaded !== 1'b1) begin errors++; $display("[TB] FAIL window_loaded got %b expected 1", loaded); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL window_load_err got %b expected 0", load_err); end
    read_at(8'h00);
    checks++; if (bus.rd_data !== 4'hA) begin errors++; $display("[TB] FAIL window_ram0 got %h expected a", bus.rd_data); end
    read_at(8'hFF);
    checks++; if (bus.rd_data !== 4'h5) begin errors++; $display("[TB] FAIL window_ram255 got %h expected 5", bus.rd_data); end
    read_at(8'h7F);
    checks++; if (bus.rd_data !== 4'h5) begin errors++; $display("[TB] FAIL window_ram127 got %h expected 5", bus.rd_data); end
  endtask

  task automatic test_reset_mid_load();
    session_begin();
    for (int i = 0; i < 100; i++) dn_write(BASE + 25'(i), 8'(i) ^ 8'hA5);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midreset_busy_before got %b expected 1", busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got %b expected 0", busy); end
    checks++; if (loaded !== 1'b0) begin errors++; $display("[TB] FAIL midreset_loaded got %b expected 0", loaded); end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_held_busy cycle %0d got %b expected 0", k, busy); end
    end
    bus.dn_download = 1'b0;
    tick();
    load_pattern(8'hA5);
    checks++; if (loaded !== 1'b1) begin errors++; $display("[TB] FAIL midreset_final_loaded got %b expected 1", loaded); end
    read_at(8'h42);
    checks++; if (bus.rd_data !== 4'h7) begin errors++; $display("[TB] FAIL midreset_read got %h expected 7", bus.rd_data); end
  endtask

  task automatic test_rd_cs_hold();
    read_at(8'h20);
    checks++; if (bus.rd_data !== 4'h5) begin errors++; $display("[TB] FAIL hold_first got %h expected 5", bus.rd_data); end
    bus.rd_addr = 8'h16;
    bus.rd_cs   = 1'b1;
    #0;
    checks++; if (bus.rd_data !== 4'h5) begin errors++; $display("[TB] FAIL hold_pre_edge got %h expected 5", bus.rd_data); end
    tick();
    checks++; if (bus.rd_data !== 4'h3) begin errors++; $display("[TB] FAIL hold_latency got %h expected 3", bus.rd_data); end
    bus.rd_cs   = 1'b0;
    bus.rd_addr = 8'h17;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (bus.rd_data !== 4'h3) begin errors++; $display("[TB] FAIL hold_cs_low cycle %0d got %h expected 3", k, bus.rd_data); end
    end
  endtask

  task automatic test_back_to_back();
    session_begin();
    for (int i = 0; i < 255; i++) dn_write(BASE + 25'(i), 8'(i) ^ 8'hA5);
    // last write shares its cycle with the download falling edge
    bus.dn_wr       = 1'b1;
    bus.dn_addr     = BASE + 25'd255;
    bus.dn_data     = 8'h5A;
    bus.dn_download = 1'b0;
    tick();
    bus.dn_wr       = 1'b0;
    // new rising edge arrives while the previous session is in DONE
    bus.dn_download = 1'b1;
    tick();
    checks++; if (loaded !== 1'b1) begin errors++; $display("[TB] FAIL b2b_loaded got %b expected 1", loaded); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy_idle got %b expected 0", busy); end
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_restart_busy got %b expected 1", busy); end
    checks++; if (loaded !== 1'b0) begin errors++; $display("[TB] FAIL b2b_restart_loaded got %b expected 0", loaded); end
    session_end();
    checks++; if (load_err !== 1'b1) begin errors++; $display("[TB] FAIL b2b_empty_err got %b expected 1", load_err); end
  endtask

`ifdef PROM_CHECKSUM_EN
  task automatic test_checksum();
    load_pattern(8'hF1 ^ 8'h00);
    session_begin();
    for (int i = 0; i < 256; i++) dn_write(BASE + 25'(i), 8'hF1);
    session_end();
    checks++; if (sum_ok_ck !== 1'b1) begin errors++; $display("[TB] FAIL ck_sum_ok got %b expected 1", sum_ok_ck); end
    checks++; if (loaded_ck !== 1'b1) begin errors++; $display("[TB] FAIL ck_loaded got %b expected 1", loaded_ck); end
    session_begin();
    for (int i = 0; i < 256; i++) dn_write(BASE + 25'(i), (i == 37) ? 8'h00 : 8'h01);
    session_end();
    checks++; if (sum_ok_ck !== 1'b0) begin errors++; $display("[TB] FAIL ck_bad_sum_ok got %b expected 0", sum_ok_ck); end
    checks++; if (load_err_ck !== 1'b1) begin errors++; $display("[TB] FAIL ck_bad_err got %b expected 1", load_err_ck); end
    checks++; if (loaded_ck !== 1'b0) begin errors++; $display("[TB] FAIL ck_bad_loaded got %b expected 0", loaded_ck); end
  endtask
`endif

  initial begin
    reset = 1'b0;
    test_reset();
    test_full_load();
    test_short_load();
    test_window_filter();
    test_reset_mid_load();
    test_rd_cs_hold();
    test_back_to_back();
`ifdef PROM_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
